// File: rtl/median_pkg.sv
// Shared types and helpers for the median filter window-address path: sequencer
// FSM states, index-width helper, pad address and tap-to-offset decoding.
package median_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam int OFF_W = 8;

  typedef struct packed {
    logic signed [OFF_W-1:0] dr;
    logic signed [OFF_W-1:0] dc;
  } tap_off_t;

  function automatic int idx_w(input int n);
    return (n < 32'sd2) ? 32'sd1 : $clog2(n);
  endfunction

  function automatic int pad_addr(input int rows, input int cols);
    return rows * cols;
  endfunction

  // Tap index is raster order with the row offset major.
  function automatic tap_off_t tap_offset(input int tap, input int k);
    tap_off_t off;
    int       h_i;
    h_i    = (k - 32'sd1) / 32'sd2;
    off.dr = OFF_W'((tap / k) - h_i);
    off.dc = OFF_W'((tap % k) - h_i);
    return off;
  endfunction

endpackage

// File: rtl/win_addr_map.sv
// Combinational (row, col, dr, dc) -> (column-major address, pad flag).
// PAD_REPLICATE_EN selects border replication instead of the pad address.
module win_addr_map
  import median_pkg::*;
#(
  parameter int ROWS = 64,
  parameter int COLS = 64,
  parameter int AW   = 13,
  parameter int RW   = 6,
  parameter int CW   = 6
) (
  input  logic [RW-1:0]          row_i,
  input  logic [CW-1:0]          col_i,
  input  logic signed [OFF_W-1:0] dr_i,
  input  logic signed [OFF_W-1:0] dc_i,
  output logic [AW-1:0]          addr_o,
  output logic                   pad_o
);

  int r_s;
  int c_s;
  int rc_s;
  int cc_s;

  // Bounds check, optional clamp and column-major linearisation (a constant
  // multiply, i.e. plain concatenation when ROWS is a power of two).
  always_comb begin
    r_s   = int'(row_i) + int'(dr_i);
    c_s   = int'(col_i) + int'(dc_i);
    rc_s  = r_s;
    cc_s  = c_s;
    pad_o = (r_s < 32'sd0) || (r_s >= ROWS) || (c_s < 32'sd0) || (c_s >= COLS);
`ifdef PAD_REPLICATE_EN
    if (r_s < 32'sd0) begin
      rc_s = 32'sd0;
    end else if (r_s >= ROWS) begin
      rc_s = ROWS - 32'sd1;
    end else begin
      rc_s = r_s;
    end
    if (c_s < 32'sd0) begin
      cc_s = 32'sd0;
    end else if (c_s >= COLS) begin
      cc_s = COLS - 32'sd1;
    end else begin
      cc_s = c_s;
    end
    addr_o = AW'(cc_s * ROWS + rc_s);
`else
    if (pad_o) begin
      addr_o = AW'(pad_addr(ROWS, COLS));
    end else begin
      addr_o = AW'(cc_s * ROWS + rc_s);
    end
`endif
  end

endmodule

// File: rtl/window_addr_seq.sv
// Scans every centre pixel of a column-major frame and issues its KxK window
// addresses one per handshake. Optional macro: PAD_REPLICATE_EN (edge replication).
module window_addr_seq
  import median_pkg::*;
#(
  parameter int ROWS = 64,
  parameter int COLS = 64,
  parameter int K    = 3,
  parameter int AW   = $clog2(ROWS * COLS) + 1
) (
  input  logic                      iClk,
  input  logic                      iRstN,
  input  logic                      iStart,
  input  logic                      iAbort,
  input  logic                      iAddrReady,
  output logic                      oAddrValid,
  output logic [AW-1:0]             oAddr,
  output logic [idx_w(K*K)-1:0]     oTap,
  output logic                      oPad,
  output logic                      oLastTap,
  output logic [idx_w(ROWS)-1:0]    oRow,
  output logic [idx_w(COLS)-1:0]    oCol,
  output logic                      oBusy,
  output logic                      oFrameDone
);

  localparam int TW = idx_w(K * K);
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  localparam logic [TW-1:0] TAP_LAST = TW'(K * K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  seq_state_e      state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [TW-1:0]   tap_q, tap_d;
  tap_off_t        off_s;
  logic            run_s;
  logic            last_tap_s;
  logic [AW-1:0]   map_addr_s;
  logic            map_pad_s;

  assign run_s      = (state_q == ST_RUN);
  assign last_tap_s = (tap_q == TAP_LAST);
  assign off_s      = tap_offset(int'(tap_q), K);

  win_addr_map #(
    .ROWS(ROWS), .COLS(COLS), .AW(AW), .RW(RW), .CW(CW)
  ) u_map (
    .row_i (row_q),
    .col_i (col_q),
    .dr_i  (off_s.dr),
    .dc_i  (off_s.dc),
    .addr_o(map_addr_s),
    .pad_o (map_pad_s)
  );

  // State and scan-position registers.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= ST_IDLE;
      row_q   <= {RW{1'b0}};
      col_q   <= {CW{1'b0}};
      tap_q   <= {TW{1'b0}};
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tap_q   <= tap_d;
    end
  end

  // Next state and scan advance; abort overrides everything, including a handshake.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tap_d   = tap_q;
    if (iAbort) begin
      state_d = ST_IDLE;
      row_d   = {RW{1'b0}};
      col_d   = {CW{1'b0}};
      tap_d   = {TW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            state_d = ST_RUN;
            row_d   = {RW{1'b0}};
            col_d   = {CW{1'b0}};
            tap_d   = {TW{1'b0}};
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (iAddrReady && last_tap_s) begin
            tap_d = {TW{1'b0}};
            if (row_q == ROW_LAST) begin
              row_d = {RW{1'b0}};
              if (col_q == COL_LAST) begin
                col_d   = {CW{1'b0}};
                state_d = ST_DONE;
              end else begin
                col_d = col_q + CW'(1);
              end
            end else begin
              row_d = row_q + RW'(1);
            end
          end else if (iAddrReady) begin
            tap_d = tap_q + TW'(1);
          end else begin
            tap_d = tap_q;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign oAddrValid = run_s;
  assign oAddr      = run_s ? map_addr_s : {AW{1'b0}};
  assign oPad       = run_s & map_pad_s;
  assign oLastTap   = run_s & last_tap_s;
  assign oTap       = tap_q;
  assign oRow       = row_q;
  assign oCol       = col_q;
  assign oBusy      = (state_q != ST_IDLE);
  assign oFrameDone = (state_q == ST_DONE);

endmodule
